// File: rtl/multicycle_control_if.sv
// Bus between the multicycle sequencer and the datapath/memories: opcode and
// flag inputs, the memory handshakes, the per-state strobes and debug state.
interface multicycle_control_if;
  logic [10:0] opCode;
  logic        zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        irWr;
  logic        pcWr;
  logic        pcSrc;
  logic        reg2Loc;
  logic        regWr;
  logic        aluSrc;
  logic [1:0]  seu;
  logic [2:0]  aluOp;
  logic        memRd;
  logic        memWr;
  logic        memToReg;
  logic        instr_done;
  logic        illegal;
  logic [2:0]  state;

  // Sequencer side.
  modport master (
    input  opCode, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, irWr, pcWr, pcSrc, reg2Loc, regWr, aluSrc,
           seu, aluOp, memRd, memWr, memToReg, instr_done, illegal, state
  );

  // Datapath / memory side.
  modport slave (
    output opCode, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, irWr, pcWr, pcSrc, reg2Loc, regWr, aluSrc,
           seu, aluOp, memRd, memWr, memToReg, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack
// memory handshakes, illegal-opcode trap and ack-timeout trap.
module multicycle_control #(
  parameter int unsigned ACK_TIMEOUT = 15  // 0 = wait forever
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_D, C_B, C_CB, C_ILL
  } class_t;

  // Counter only ever reaches ACK_TIMEOUT-1 before trapping.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  class_t        cls;
  logic [2:0]    alu_op_dec;
  logic          is_ldur;
  logic          is_cbnz;
  logic          waiting;
  logic          ack;
  logic          timeout_hit;
  logic          unused_op_bits;

  // Opcode bits that never distinguish instructions in this subset.
  assign unused_op_bits = ^{bus.opCode[4], bus.opCode[2], bus.opCode[0]};

  // Instruction class and ALU function from opCode[10:5] plus modifier bits.
  always_comb begin
    cls        = C_ILL;
    alu_op_dec = 3'b000;
    is_ldur    = 1'b0;
    is_cbnz    = 1'b0;
    case (bus.opCode[10:5])
      6'b000101: cls = C_B;
      6'b100010: begin cls = C_R; alu_op_dec = bus.opCode[3] ? 3'b000 : 3'b010; end
      6'b100100: begin cls = C_I; alu_op_dec = bus.opCode[3] ? 3'b000 : 3'b010; end
      6'b101010: begin cls = C_R; alu_op_dec = 3'b011; end
      6'b101100: begin cls = C_I; alu_op_dec = 3'b011; end
      6'b101101: begin cls = C_CB; is_cbnz = bus.opCode[3]; end
      6'b110010: begin cls = C_R; alu_op_dec = 3'b001; end
      6'b110100: begin cls = C_I; alu_op_dec = 3'b001; end
      6'b111110: begin cls = C_D; is_ldur = bus.opCode[1]; end
      default:   cls = C_ILL;
    endcase
  end

  // The ack that matters depends on which handshake is open; acks seen
  // outside FETCH/MEM are ignored because nothing is waiting on them.
  assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack         = (state_q == S_FETCH) ? bus.imem_ack : bus.dmem_ack;
  assign timeout_hit = (ACK_TIMEOUT != 0) && waiting && !ack &&
                       (cnt_q == CW'(ACK_TIMEOUT - 1));

  // Next state and per-state strobes; reset forces every output low so a
  // reset mid-handshake can never produce a write.
  always_comb begin
    state_d        = state_q;
    bus.imem_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.irWr       = 1'b0;
    bus.pcWr       = 1'b0;
    bus.pcSrc      = 1'b0;
    bus.reg2Loc    = 1'b0;
    bus.regWr      = 1'b0;
    bus.aluSrc     = 1'b0;
    bus.seu        = 2'b00;
    bus.aluOp      = 3'b000;
    bus.memRd      = 1'b0;
    bus.memWr      = 1'b0;
    bus.memToReg   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.irWr = 1'b1;
          bus.pcWr = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.reg2Loc = (cls == C_CB) || ((cls == C_D) && !is_ldur);
        state_d     = (cls == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          C_R: begin
            bus.aluOp = alu_op_dec;
            state_d   = S_WB;
          end
          C_I: begin
            bus.aluSrc = 1'b1;
            bus.seu    = 2'b00;
            bus.aluOp  = alu_op_dec;
            state_d    = S_WB;
          end
          C_D: begin
            bus.aluSrc = 1'b1;
            bus.seu    = 2'b11;
            bus.aluOp  = 3'b000;
            state_d    = S_MEM;
          end
          C_B: begin
            bus.seu        = 2'b01;
            bus.pcWr       = 1'b1;
            bus.pcSrc      = 1'b1;
            bus.instr_done = 1'b1;
          end
          C_CB: begin
            bus.seu        = 2'b10;
            bus.aluOp      = 3'b100;
            bus.pcWr       = bus.zero ^ is_cbnz;
            bus.pcSrc      = bus.zero ^ is_cbnz;
            bus.instr_done = 1'b1;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.memRd    = is_ldur;
        if (bus.dmem_ack) begin
          // Store commits only in the ack cycle, so memWr is a single pulse.
          bus.memWr = !is_ldur;
          if (is_ldur) begin
            state_d = S_WB;
          end else begin
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        bus.regWr      = 1'b1;
        bus.memToReg   = is_ldur;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.irWr       = 1'b0;
      bus.pcWr       = 1'b0;
      bus.pcSrc      = 1'b0;
      bus.reg2Loc    = 1'b0;
      bus.regWr      = 1'b0;
      bus.aluSrc     = 1'b0;
      bus.seu        = 2'b00;
      bus.aluOp      = 3'b000;
      bus.memRd      = 1'b0;
      bus.memWr      = 1'b0;
      bus.memToReg   = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

  // Wait counter restarts whenever the state changes (i.e. on entry to
  // FETCH/MEM) and counts cycles spent without ack.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && !ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state = state_q;

endmodule
